// File: rtl/audio_serializer_24.sv
// rtl/audio_serializer_24.sv - 24-bit parallel-to-serial audio transmitter, MSB first
//
// Accepts one word per d_valid/d_ready handshake and shifts it out on sdata,
// holding each bit for CLKS_PER_BIT clocks. frame marks the MSB bit period,
// done pulses on the last clock of the word.
//
// Optional feature macro: AUDIO_SER_PARITY_EN
//   When defined, an extra bit period carrying even parity (XOR of the data
//   bits captured at accept) follows the LSB, and done moves to its last cycle.
//
// Parameters:
//   WIDTH         bits per word (2..32)
//   CLKS_PER_BIT  clocks each bit is held on sdata (>= 2)
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high reset
//   d        parallel word, sampled only on the accept edge
//   d_valid  producer has a word on d
//   d_ready  high exactly when idle
//   sdata    serial data, MSB first, 0 when idle
//   frame    high during the whole MSB bit period
//   busy     high while a word (and parity bit) is being sent
//   done     one-cycle pulse on the last clock of the word

module audio_serializer_24 #(
    parameter int WIDTH        = 24,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             sdata,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

`ifdef AUDIO_SER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
`ifdef AUDIO_SER_PARITY_EN
    logic             parity_bit;
`endif

    logic div_last;
    logic bit_last;
    logic accept;

    assign div_last = (div_cnt == DIV_LAST);
    assign bit_last = (bit_cnt == BIT_LAST);
    assign accept   = (state == IDLE) && d_valid;

    // Next-state and output decode. Outputs are purely a function of state
    // and counters so the MSB is visible in the cycle right after accept.
    always_comb begin
        state_next = state;
        d_ready    = 1'b0;
        sdata      = 1'b0;
        frame      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                d_ready = 1'b1;
                if (d_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                sdata = shreg[WIDTH-1];
                frame = (bit_cnt == '0);
                if (div_last && bit_last) begin
`ifdef AUDIO_SER_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = IDLE;
                    done       = 1'b1;
`endif
                end
            end
`ifdef AUDIO_SER_PARITY_EN
            PARITY: begin
                busy  = 1'b1;
                sdata = parity_bit;
                if (div_last) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: shift register, bit counter and bit-period divider.
    // d is captured only on the accept edge, so changes to d while busy
    // never reach sdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
`ifdef AUDIO_SER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (accept) begin
            shreg      <= d;
            bit_cnt    <= '0;
            div_cnt    <= '0;
`ifdef AUDIO_SER_PARITY_EN
            parity_bit <= ^d;
`endif
        end else if (state == SHIFT) begin
            if (div_last) begin
                div_cnt <= '0;
                shreg   <= shreg << 1;
                // Return to 0 after the last bit rather than incrementing,
                // so a power-of-two WIDTH never overflows the counter.
                if (bit_last) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
`ifdef AUDIO_SER_PARITY_EN
        else if (state == PARITY) begin
            if (div_last) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_audio_serializer_24.sv
// tb/tb_audio_serializer_24.sv - self-checking bench for audio_serializer_24

module tb_audio_serializer_24;

    localparam int CPB = 4;
`ifdef AUDIO_SER_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int NDATA = 24 * CPB;
    localparam int N     = NDATA + PAR_EN * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] d;
    logic        d_valid;
    logic        d_ready;
    logic        sdata;
    logic        frame;
    logic        busy;
    logic        done;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [23:0] d;
        logic [23:0] exp_bits;
        logic        exp_par;
    } vec_t;

    vec_t vecs [6];

    audio_serializer_24 #(
        .WIDTH(24),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .d(d),
        .d_valid(d_valid),
        .d_ready(d_ready),
        .sdata(sdata),
        .frame(frame),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle holding an idle state; the word is accepted at the
    // end of this cycle, and the task returns in the first cycle of the frame.
    task automatic start_word(input logic [23:0] w);
        d       = w;
        d_valid = 1'b1;
        check("accept ready", {31'd0, d_ready}, 32'd1);
        step();
        d_valid = 1'b0;
    endtask

    // Observes cycles k+1..k+N of a frame, then checks the idle cycle k+N+1.
    task automatic observe(input string name, input logic [23:0] exp_bits,
                           input logic exp_par, input bit poke);
        int   bit_err   = 0;
        int   frame_err = 0;
        int   busy_err  = 0;
        int   done_cnt  = 0;
        int   done_at   = -1;
        logic exp_s;
        for (int c = 1; c <= N; c++) begin
            if (c <= NDATA) exp_s = exp_bits[23 - (c - 1) / CPB];
            else            exp_s = exp_par;
            if (sdata !== exp_s) bit_err++;
            if (frame !== (c <= CPB)) frame_err++;
            if (busy !== 1'b1 || d_ready !== 1'b0) busy_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (poke) begin
                if (c == 20) begin
                    d       = 24'h123456;
                    d_valid = 1'b1;
                end
                if (c == 40) d_valid = 1'b0;
            end
            step();
        end
        check({name, " sdata bit errors"}, bit_err, 0);
        check({name, " frame errors"}, frame_err, 0);
        check({name, " busy/ready errors"}, busy_err, 0);
        check({name, " done count"}, done_cnt, 1);
        check({name, " done cycle"}, done_at, N);
        check({name, " idle d_ready"}, {31'd0, d_ready}, 32'd1);
        check({name, " idle sdata"}, {31'd0, sdata}, 32'd0);
        check({name, " idle busy"}, {31'd0, busy}, 32'd0);
        check({name, " idle done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int err;

        vecs[0] = '{24'hA50F3C, 24'b1010_0101_0000_1111_0011_1100, 1'b0};
        vecs[1] = '{24'h800000, 24'b1000_0000_0000_0000_0000_0000, 1'b1};
        vecs[2] = '{24'h5A5A5A, 24'b0101_1010_0101_1010_0101_1010, 1'b0};
        vecs[3] = '{24'h000003, 24'b0000_0000_0000_0000_0000_0011, 1'b0};
        vecs[4] = '{24'hFFFFFF, 24'b1111_1111_1111_1111_1111_1111, 1'b0};
        vecs[5] = '{24'h000001, 24'b0000_0000_0000_0000_0000_0001, 1'b1};

        // Reset held two cycles with a word offered: nothing is accepted.
        reset   = 1'b1;
        d_valid = 1'b1;
        d       = 24'hABCDEF;
        step();
        step();
        reset   = 1'b0;
        d_valid = 1'b0;
        check("reset d_ready", {31'd0, d_ready}, 32'd1);
        check("reset sdata", {31'd0, sdata}, 32'd0);
        check("reset frame", {31'd0, frame}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        err = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b0 || sdata !== 1'b0) err++;
            step();
        end
        check("reset no word accepted", err, 0);

        // Table of single words.
        for (int i = 0; i < 6; i++) begin
            start_word(vecs[i].d);
            observe($sformatf("vec%0d", i), vecs[i].exp_bits, vecs[i].exp_par, 1'b0);
            step();
        end

        // Back-to-back with d_valid held high.
        d       = 24'hFFFFFF;
        d_valid = 1'b1;
        step();
        d = 24'h000001;
        observe("b2b first", 24'hFFFFFF, 1'b0, 1'b0);
        step();
        d_valid = 1'b0;
        check("b2b second frame start", {31'd0, frame}, 32'd1);
        observe("b2b second", 24'h000001, 1'b1, 1'b0);

        // d / d_valid changes while busy are ignored.
        step();
        start_word(24'h800000);
        observe("ignore busy", 24'h800000, 1'b1, 1'b1);
        err = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b0 || sdata !== 1'b0) err++;
            step();
        end
        check("ignore busy no extra frame", err, 0);

        // Reset in the middle of bit 10.
        start_word(24'hFFFFFF);
        repeat (40) step();
        check("midreset bit10 before reset", {31'd0, sdata}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset d_ready", {31'd0, d_ready}, 32'd1);
        check("midreset sdata", {31'd0, sdata}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset frame", {31'd0, frame}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        err = 0;
        for (int i = 0; i < N + 10; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) err++;
            step();
        end
        check("midreset no done", err, 0);
        start_word(24'h000003);
        observe("after reset", 24'h000003, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
